regfile_exec_seq: RTL and testbench

- Multi-cycle execute sequencer directly downstream of the 8x16 register file.
- Accepts one ALU command, then for each command:
  - reads two source registers over two cycles, latching them into operand registers A and B;
  - shifts B, performs the ALU operation and latches the result into C, updating status flags;
  - writes C back to the destination register through the register-file write port.
- Drives the regfile's readnum/writenum/write/data_in and consumes its combinational data_out.

---
 rtl/regfile_exec_seq_if.sv | 35 +++
 rtl/regfile_exec_seq.sv | 123 ++++++++++++
 tb/tb_regfile_exec_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_exec_seq_if.sv
// Bundle of the sequencer's command, register-file and status signals.
// The slave side is the sequencer; the master side supplies commands and the
// register file's combinational read data (in practice the parent/regfile wrapper).
interface regfile_exec_seq_if #(
  parameter int WIDTH = 16,
  parameter int RSEL  = 3
);
  // command request
  logic             start;
  logic [1:0]       op;
  logic [1:0]       shift;
  logic [RSEL-1:0]  rd;
  logic [RSEL-1:0]  rn;
  logic [RSEL-1:0]  rm;
  // register file side
  logic [WIDTH-1:0] reg_data_out;
  logic [RSEL-1:0]  readnum;
  logic [RSEL-1:0]  writenum;
  logic             write;
  logic [WIDTH-1:0] data_in;
  // progress / result flags
  logic             busy;
  logic             done;
  logic [2:0]       status;

  modport master (
    output start, op, shift, rd, rn, rm, reg_data_out,
    input  readnum, writenum, write, data_in, busy, done, status
  );

  modport slave (
    input  start, op, shift, rd, rn, rm, reg_data_out,
    output readnum, writenum, write, data_in, busy, done, status
  );
endinterface

// File: rtl/regfile_exec_seq.sv
// Execute sequencer: read Rn, read Rm, shift/ALU into C, write C back to Rd.
// Latency: start taken at E0, write high in cycle after E3, done high in cycle after E4.
// Backpressure: none; start is sampled only in IDLE, ignored (not queued) while busy.
// Ports: clk, reset (synchronous, active-high); bus (slave modport) carries
//   start/op/shift/rd/rn/rm and reg_data_out in; readnum/writenum/write/data_in,
//   busy/done/status {V,N,Z} out. All outputs are decoded from state and registers.
module regfile_exec_seq #(
  parameter int WIDTH = 16,
  parameter int RSEL  = 3
) (
  input  logic              clk,
  input  logic              reset,
  regfile_exec_seq_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RA   = 3'd1;
  localparam logic [2:0] S_RB   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_DN   = 3'd5;

  logic [2:0]       state;
  logic [1:0]       op_q;
  logic [1:0]       shift_q;
  logic [RSEL-1:0]  rd_q;
  logic [RSEL-1:0]  rn_q;
  logic [RSEL-1:0]  rm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [2:0]       status_q;

  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;

  // B shifter
  always_comb begin
    b_sh = b_q;
    case (shift_q)
      2'b01:   b_sh = {b_q[MSB-1:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_q[MSB:1]};
      2'b11:   b_sh = {b_q[MSB], b_q[MSB:1]};
      default: b_sh = b_q;
    endcase
  end

  // ALU; overflow only meaningful for ADD/SUB, judged from operand/result signs
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (op_q)
      2'b00: begin
        alu_res = a_q + b_sh;
        alu_v   = (a_q[MSB] == b_sh[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      2'b01: begin
        alu_res = a_q - b_sh;
        alu_v   = (a_q[MSB] != b_sh[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      2'b10:   alu_res = a_q & b_sh;
      default: alu_res = ~b_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      shift_q  <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            shift_q <= bus.shift;
            rd_q    <= bus.rd;
            rn_q    <= bus.rn;
            rm_q    <= bus.rm;
            state   <= S_RA;
          end
        end
        S_RA: begin
          a_q   <= bus.reg_data_out;
          state <= S_RB;
        end
        S_RB: begin
          b_q   <= bus.reg_data_out;
          state <= S_EX;
        end
        S_EX: begin
          c_q      <= alu_res;
          status_q <= {alu_v, alu_res[MSB], (alu_res == '0)};
          state    <= S_WB;
        end
        // the register file captures data_in at the edge leaving WB
        S_WB:    state <= S_DN;
        S_DN:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.readnum  = (state == S_RA) ? rn_q :
                        (state == S_RB) ? rm_q : '0;
  assign bus.writenum = (state == S_WB) ? rd_q : '0;
  assign bus.write    = (state == S_WB);
  assign bus.data_in  = c_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DN);
  assign bus.status   = status_q;

endmodule

// File: tb/tb_regfile_exec_seq.sv
// Bench for regfile_exec_seq: behavioural 8x16 register file, a table of
// directed commands, hand-written reset/start-during-busy sequences, and
// random commands checked against an arithmetic reference model.
module tb_regfile_exec_seq;

  logic clk;
  logic reset;

  regfile_exec_seq_if #(.WIDTH(16), .RSEL(3)) bus ();

  regfile_exec_seq #(.WIDTH(16), .RSEL(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural register file; pokes share the single write process
  logic [15:0] rf [8];
  logic        poke_en;
  logic [2:0]  poke_addr;
  logic [15:0] poke_val;

  always @(posedge clk) begin
    if (bus.write) rf[bus.writenum] <= bus.data_in;
    else if (poke_en) rf[poke_addr] <= poke_val;
  end

  assign bus.reg_data_out = rf[bus.readnum];

  // reference state
  logic [15:0] mdl [8];
  logic [2:0]  mdl_status;

  int total;
  int bad;

  typedef struct {
    logic        pre_en;
    logic [2:0]  pre_reg;
    logic [15:0] pre_val;
    logic [1:0]  op;
    logic [1:0]  sh;
    logic [2:0]  rd;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [15:0] exp_res;
    logic [2:0]  exp_st;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference: signed integer arithmetic, overflow = out of 16-bit signed range
  function automatic logic [18:0] ref_exec(input logic [1:0] op, input logic [1:0] sh,
                                           input logic [15:0] a, input logic [15:0] b);
    int ai, bi, bs, sa, sb, r;
    logic v;
    logic [15:0] res;
    ai = a;
    bi = b;
    case (sh)
      2'd0:    bs = bi;
      2'd1:    bs = (bi * 2) % 65536;
      2'd2:    bs = bi / 2;
      default: bs = bi / 2 + ((bi >= 32768) ? 32768 : 0);
    endcase
    sa = (ai >= 32768) ? ai - 65536 : ai;
    sb = (bs >= 32768) ? bs - 65536 : bs;
    v = 1'b0;
    case (op)
      2'd0: begin r = sa + sb; v = (r > 32767) || (r < -32768); end
      2'd1: begin r = sa - sb; v = (r > 32767) || (r < -32768); end
      2'd2:    r = ai & bs;
      default: r = 65535 - bs;
    endcase
    res = r[15:0];
    return {v, res[15], (res == 16'd0), res};
  endfunction

  task automatic poke(input logic [2:0] addr, input logic [15:0] val);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = addr;
    poke_val  = val;
    @(posedge clk);
    #1;
    poke_en   = 1'b0;
    mdl[addr] = val;
  endtask

  // Issue one command from IDLE. lat = edges after the accept edge at which done
  // is first seen high; returns after the following edge (back in IDLE).
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] sh, input logic [2:0] rd,
                         input logic [2:0] rn, input logic [2:0] rm,
                         output int lat, output int wcnt, output int wnum);
    int edges;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.shift = sh;
    bus.rd    = rd;
    bus.rn    = rn;
    bus.rm    = rm;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // fields are don't-care once accepted
    bus.op    = 2'($urandom);
    bus.shift = 2'($urandom);
    bus.rd    = 3'($urandom);
    bus.rn    = 3'($urandom);
    bus.rm    = 3'($urandom);
    edges = 0;
    lat   = -1;
    wcnt  = 0;
    wnum  = -1;
    while (edges < 20 && lat < 0) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.write) begin
        wcnt++;
        wnum = int'(bus.writenum);
      end
      if (bus.done) lat = edges;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, wcnt, wnum, dcnt;
    logic [18:0] r;
    logic [1:0] op, sh;
    logic [2:0] rd, rn, rm;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    poke_en = 1'b0;
    poke_addr = '0;
    poke_val = '0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.shift = '0;
    bus.rd = '0;
    bus.rn = '0;
    bus.rm = '0;
    for (int i = 0; i < 8; i++) begin
      rf[i]  = 16'h0;
      mdl[i] = 16'h0;
    end
    mdl_status = 3'b000;

    //            pre   reg   val       op     sh     rd    rn    rm    result    {V,N,Z}
    tbl[0] = '{1'b0, 3'd0, 16'h0000, 2'b00, 2'b01, 3'd0, 3'd1, 3'd2, 16'h000B, 3'b000};
    tbl[1] = '{1'b0, 3'd0, 16'h0000, 2'b01, 2'b00, 3'd3, 3'd2, 3'd1, 16'hFFFE, 3'b010};
    tbl[2] = '{1'b0, 3'd0, 16'h0000, 2'b00, 2'b00, 3'd6, 3'd4, 3'd5, 16'h8000, 3'b110};
    tbl[3] = '{1'b0, 3'd0, 16'h0000, 2'b10, 2'b10, 3'd7, 3'd1, 3'd2, 16'h0001, 3'b000};
    tbl[4] = '{1'b1, 3'd5, 16'hFFFF, 2'b11, 2'b00, 3'd7, 3'd0, 3'd5, 16'h0000, 3'b001};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_readnum", 32'(bus.readnum), 32'd0);
    chk("rst_writenum", 32'(bus.writenum), 32'd0);
    chk("rst_status", 32'(bus.status), 32'd0);
    chk("rst_data_in", 32'(bus.data_in), 32'd0);
    reset = 1'b0;

    poke(3'd1, 16'h0005);
    poke(3'd2, 16'h0003);
    poke(3'd4, 16'h7FFF);
    poke(3'd5, 16'h0001);

    // directed table
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].pre_en) poke(tbl[i].pre_reg, tbl[i].pre_val);
      run_cmd(tbl[i].op, tbl[i].sh, tbl[i].rd, tbl[i].rn, tbl[i].rm, lat, wcnt, wnum);
      chk($sformatf("tbl%0d_result", i), 32'(rf[tbl[i].rd]), 32'(tbl[i].exp_res));
      chk($sformatf("tbl%0d_status", i), 32'(bus.status), 32'(tbl[i].exp_st));
      chk($sformatf("tbl%0d_done_lat", i), 32'(lat), 32'd4);
      chk($sformatf("tbl%0d_wr_count", i), 32'(wcnt), 32'd1);
      chk($sformatf("tbl%0d_writenum", i), 32'(wnum), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_idle", i), 32'(bus.busy), 32'd0);
      mdl[tbl[i].rd] = tbl[i].exp_res;
      mdl_status = tbl[i].exp_st;
    end

    // reset while in EX: command abandoned, nothing written, status cleared
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.shift = 2'b00;
    bus.rd = 3'd4;
    bus.rn = 3'd1;
    bus.rm = 3'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("ex_busy_before_reset", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstex_busy", 32'(bus.busy), 32'd0);
    chk("rstex_write", 32'(bus.write), 32'd0);
    chk("rstex_done", 32'(bus.done), 32'd0);
    chk("rstex_status", 32'(bus.status), 32'd0);
    mdl_status = 3'b000;
    wcnt = 0;
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.write) wcnt++;
      if (bus.done) dcnt++;
    end
    chk("rstex_no_write", 32'(wcnt), 32'd0);
    chk("rstex_no_done", 32'(dcnt), 32'd0);
    chk("rstex_rd_kept", 32'(rf[4]), 32'(mdl[4]));

    // ADD R1=R1+R1 with start re-pulsed in RB and EX: exactly one command runs
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.shift = 2'b00;
    bus.rd = 3'd1;
    bus.rn = 3'd1;
    bus.rm = 3'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wcnt = 0;
    dcnt = 0;
    wnum = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.write) begin
        wcnt++;
        wnum = int'(bus.writenum);
      end
      if (bus.done) dcnt++;
      if (k == 1) begin
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.rd = 3'd2;
        bus.rn = 3'd3;
        bus.rm = 3'd3;
      end
      if (k == 3) bus.start = 1'b0;
    end
    chk("busy_start_wr_count", 32'(wcnt), 32'd1);
    chk("busy_start_done_count", 32'(dcnt), 32'd1);
    chk("busy_start_writenum", 32'(wnum), 32'd1);
    chk("busy_start_r1", 32'(rf[1]), 32'h000A);
    chk("busy_start_r2_kept", 32'(rf[2]), 32'(mdl[2]));
    chk("busy_start_status", 32'(bus.status), 32'b000);
    mdl[1] = 16'h000A;

    // random commands against the reference model
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      sh = 2'($urandom);
      rd = 3'($urandom);
      rn = 3'($urandom);
      rm = 3'($urandom);
      if ($urandom_range(1, 0) == 1) poke(rn, 16'($urandom));
      if ($urandom_range(1, 0) == 1) poke(rm, 16'($urandom));
      r = ref_exec(op, sh, mdl[rn], mdl[rm]);
      run_cmd(op, sh, rd, rn, rm, lat, wcnt, wnum);
      mdl[rd] = r[15:0];
      mdl_status = r[18:16];
      chk($sformatf("rnd%0d_status", n), 32'(bus.status), 32'(mdl_status));
      chk($sformatf("rnd%0d_done_lat", n), 32'(lat), 32'd4);
      chk($sformatf("rnd%0d_wr_count", n), 32'(wcnt), 32'd1);
      chk($sformatf("rnd%0d_writenum", n), 32'(wnum), 32'(rd));
      for (int i = 0; i < 8; i++)
        chk($sformatf("rnd%0d_r%0d", n, i), 32'(rf[i]), 32'(mdl[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
